branch_update_queue: RTL and testbench
======================================

# branch_update_queue

Buffers resolved control-transfer updates produced at commit and delivers them one per cycle to the fetch-side predictor update interface: the `updatePC`/`updateNPC`/`updateCtrlType`/`updateDir`/`updateCounter`/`updateEn` bundle that the fetch-to-decode pipeline register carries into the branch predictor. It is the producing end of that interface. It accepts up to two updates per cycle, computes the new 2-bit saturating counter, and holds each update until the predictor accepts it. Updates are architectural, so pipeline flushes never discard them.

## Interface
Parameters:
- `DEPTH`, 8, FIFO storage entries; must be a power of two and ≥ 4.
- `PC_W`, `SIZE_PC`, PC width.
- `TYPE_W`, `BRANCH_TYPE`, control-type width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wrEn0_i`, `wrEn1_i`  in  1 each  write requests; port 0 is older than port 1.
- `wrPC0_i`, `wrPC1_i`  in  PC_W  branch PC.
- `wrNPC0_i`, `wrNPC1_i`  in  PC_W  resolved next PC.
- `wrCtrlType0_i`, `wrCtrlType1_i`  in  TYPE_W  control type.
- `wrDir0_i`, `wrDir1_i`  in  1  resolved direction (1 = taken).
- `wrCounter0_i`, `wrCounter1_i`  in  2  counter value read at prediction time.
- `stall_o`  out  1  fewer than 2 FIFO slots free; commit must not write.
- `updateReady_i`  in  1  predictor accepts the presented update this cycle.
- `updatePC_o`, `updateNPC_o`  out  PC_W  presented update.
- `updateCtrlType_o`  out  TYPE_W  presented control type.
- `updateDir_o`  out  1  presented direction.
- `updateCounter_o`  out  2  new counter value.
- `updateEn_o`  out  1  output slot holds a valid update.
- `overflow_o`  out  1  sticky error flag: a write arrived while `stall_o` was asserted.

## Operation
- Storage is a `DEPTH`-entry circular FIFO with head and tail pointers, plus one registered output slot that drives all `update*_o` ports.
- Enqueue:
  - Both writes in one cycle: entry 0 goes to tail, entry 1 to tail+1.
  - A lone write on either port takes a single slot.
  - Pointers wrap modulo `DEPTH`.
  - `count` is log2(DEPTH)+1 bits and changes by writes minus pops, range 0..DEPTH.
- Counter arithmetic at enqueue:
  - Dir = 1: new = min(ctr+1, 3).
  - Dir = 0: new = max(ctr−1, 0).
  - Applied for every control type.
- Output slot load condition: `!updateEn_o || updateReady_i`.
  - If the condition holds and the FIFO is non-empty: pop the head into the slot and set `updateEn_o`.
  - If the condition holds and the FIFO is empty: clear `updateEn_o`.
- Backpressure: while `updateEn_o && !updateReady_i`, the slot contents are held stable.
- `stall_o = (count >= DEPTH−1)`, decoded combinationally from registered `count`.
- Write while `stall_o` = 1:
  - The write is dropped.
  - `overflow_o` sets and stays set until reset.
  - FIFO state is unchanged for that port.
- `flush_i` does not exist. Updates survive all pipeline recoveries.
- Reset (asynchronous, any time, including mid-drain):
  - `count`, pointers, `updateEn_o`, and `overflow_o` go to 0.
  - All `update*_o` outputs go to 0; `stall_o` reads 0.
  - Queued contents are lost.

## Timing
- Baseline latency: a write in cycle N appears on outputs at N+2 (FIFO in N, slot load at N+1 edge), provided the slot is free.
- Throughput: one update delivered per cycle while `updateReady_i` = 1.
- Simultaneous pop and double push with `count` = DEPTH−2: legal; the result is `count` = DEPTH−1 and `stall_o` = 1 next cycle.
- `stall_o` reflects state after the previous edge only. A pop in the current cycle does not deassert it until the next cycle.

## Configuration
- `BUQ_BYPASS_EN` defined:
  - When the FIFO is empty and the slot is loadable, the oldest write of the cycle loads the output slot directly, giving latency N+1.
  - Any second write goes to the FIFO.
- `BUQ_BYPASS_EN` undefined: all writes pass through the FIFO, giving latency N+2.

## Test plan
- Reset, then one write (PC=0x100, NPC=0x200, dir=1, ctr=2), ready=1 → `updateEn_o` at N+2 (N+1 with bypass), counter=3, then `updateEn_o` drops.
- Counter saturation: writes with dir=1/ctr=3, dir=0/ctr=0, dir=0/ctr=2 → counters 3, 0, 1 delivered in order.
- `DEPTH`=8, ready=0, four double-writes → `stall_o` high once count=7. A further write sets `overflow_o`, and that write is never delivered.
- Double write (PCs A, B), ready=1 → A delivered before B, on consecutive cycles.
- Ready toggled 1,0,0,1 during a drain of 5 entries → outputs are stable while ready=0; all 5 are delivered in order with no duplicates.
- Assert `reset_n`=0 mid-cycle with 4 entries queued → `updateEn_o`, `stall_o`, and `overflow_o` are 0 immediately. After release, there is no output until a new write.

Source files
------------

// File: rtl/branch_update_queue_if.sv
// branch_update_queue_if: bundle between the commit/predictor environment and
// the branch update queue. The "slave" modport is the queue itself; the
// "master" modport is the environment (commit writes plus predictor ready).
interface branch_update_queue_if #(
    parameter int PC_W   = 32,
    parameter int TYPE_W = 3
);
    logic              wrEn0_i;
    logic              wrEn1_i;
    logic [PC_W-1:0]   wrPC0_i;
    logic [PC_W-1:0]   wrPC1_i;
    logic [PC_W-1:0]   wrNPC0_i;
    logic [PC_W-1:0]   wrNPC1_i;
    logic [TYPE_W-1:0] wrCtrlType0_i;
    logic [TYPE_W-1:0] wrCtrlType1_i;
    logic              wrDir0_i;
    logic              wrDir1_i;
    logic [1:0]        wrCounter0_i;
    logic [1:0]        wrCounter1_i;
    logic              stall_o;
    logic              updateReady_i;
    logic [PC_W-1:0]   updatePC_o;
    logic [PC_W-1:0]   updateNPC_o;
    logic [TYPE_W-1:0] updateCtrlType_o;
    logic              updateDir_o;
    logic [1:0]        updateCounter_o;
    logic              updateEn_o;
    logic              overflow_o;

    modport slave (
        input  wrEn0_i, wrEn1_i, wrPC0_i, wrPC1_i, wrNPC0_i, wrNPC1_i,
        input  wrCtrlType0_i, wrCtrlType1_i, wrDir0_i, wrDir1_i,
        input  wrCounter0_i, wrCounter1_i, updateReady_i,
        output stall_o, updatePC_o, updateNPC_o, updateCtrlType_o,
        output updateDir_o, updateCounter_o, updateEn_o, overflow_o
    );

    modport master (
        output wrEn0_i, wrEn1_i, wrPC0_i, wrPC1_i, wrNPC0_i, wrNPC1_i,
        output wrCtrlType0_i, wrCtrlType1_i, wrDir0_i, wrDir1_i,
        output wrCounter0_i, wrCounter1_i, updateReady_i,
        input  stall_o, updatePC_o, updateNPC_o, updateCtrlType_o,
        input  updateDir_o, updateCounter_o, updateEn_o, overflow_o
    );
endinterface

// File: rtl/branch_update_queue.sv
// branch_update_queue: buffers up to two resolved branch updates per cycle,
// applies the 2-bit saturating counter step, and presents them one at a time
// through a registered output slot to the predictor.
// Optional feature: define BUQ_BYPASS_EN to let the oldest write of a cycle
// load the empty output slot directly (one cycle less latency).
module branch_update_queue #(
    parameter int DEPTH  = 8,
    parameter int PC_W   = 32,
    parameter int TYPE_W = 3
) (
    input logic                 clk,
    input logic                 reset_n,
    branch_update_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef BUQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   npc;
        logic [TYPE_W-1:0] ctype;
        logic              dir;
        logic [1:0]        ctr;
    } entry_t;

    function automatic logic [1:0] step_ctr(input logic dir, input logic [1:0] ctr);
        if (dir) return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        else     return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    endfunction

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, tail_p1;
    logic [CNT_W-1:0]  count_q, count_d;
    entry_t            slot_q, slot_d;
    logic              upd_en_q, upd_en_d;
    logic              overflow_q, overflow_d;

    entry_t ent0, ent1, push_a_data, push_b_data;
    logic   stall, acc0, acc1, load, fifo_empty, pop, byp;
    logic   rem0, rem1, push_a, push_b;

    // Accept/drop decisions, slot reload, and next pointer/count values.
    always_comb begin
        stall      = count_q >= CNT_W'(DEPTH - 1);
        ent0       = '{pc: bus.wrPC0_i, npc: bus.wrNPC0_i, ctype: bus.wrCtrlType0_i,
                       dir: bus.wrDir0_i, ctr: step_ctr(bus.wrDir0_i, bus.wrCounter0_i)};
        ent1       = '{pc: bus.wrPC1_i, npc: bus.wrNPC1_i, ctype: bus.wrCtrlType1_i,
                       dir: bus.wrDir1_i, ctr: step_ctr(bus.wrDir1_i, bus.wrCounter1_i)};
        acc0       = bus.wrEn0_i && !stall;
        acc1       = bus.wrEn1_i && !stall;
        load       = !upd_en_q || bus.updateReady_i;
        fifo_empty = (count_q == '0);
        pop        = load && !fifo_empty;
        byp        = BYPASS && load && fifo_empty && (acc0 || acc1);
        // the bypassed write is the oldest accepted one; whatever is left is queued
        rem0        = acc0 && !byp;
        rem1        = acc1 && !(byp && !acc0);
        push_a      = rem0 || rem1;
        push_b      = rem0 && rem1;
        push_a_data = rem0 ? ent0 : ent1;
        push_b_data = ent1;

        slot_d   = slot_q;
        upd_en_d = upd_en_q;
        if (load) begin
            if (pop) begin
                slot_d   = mem_q[head_q];
                upd_en_d = 1'b1;
            end else if (byp) begin
                slot_d   = acc0 ? ent0 : ent1;
                upd_en_d = 1'b1;
            end else begin
                upd_en_d = 1'b0;
            end
        end

        tail_p1    = tail_q + PTR_W'(1);
        head_d     = head_q + PTR_W'(pop);
        tail_d     = tail_q + PTR_W'(push_a) + PTR_W'(push_b);
        count_d    = count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
        overflow_d = overflow_q || (stall && (bus.wrEn0_i || bus.wrEn1_i));
    end

    // Control state and output slot; reset discards queued contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            slot_q     <= '0;
            upd_en_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            slot_q     <= slot_d;
            upd_en_q   <= upd_en_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; entries are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (push_a) mem_q[tail_q]  <= push_a_data;
        if (push_b) mem_q[tail_p1] <= push_b_data;
    end

    assign bus.stall_o          = stall;
    assign bus.updatePC_o       = slot_q.pc;
    assign bus.updateNPC_o      = slot_q.npc;
    assign bus.updateCtrlType_o = slot_q.ctype;
    assign bus.updateDir_o      = slot_q.dir;
    assign bus.updateCounter_o  = slot_q.ctr;
    assign bus.updateEn_o       = upd_en_q;
    assign bus.overflow_o       = overflow_q;
endmodule

// File: tb/tb_branch_update_queue.sv
// tb_branch_update_queue: directed and random stimulus for branch_update_queue,
// checked every cycle against a queue-based reference model.
module tb_branch_update_queue;
    localparam int DEPTH  = 8;
    localparam int PC_W   = 32;
    localparam int TYPE_W = 3;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   npc;
        logic [TYPE_W-1:0] ty;
        logic              dir;
        logic [1:0]        ctr;
    } ent_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    ent_t mq[$];
    ent_t ms;
    bit   msv;
    bit   movf;

    branch_update_queue_if #(.PC_W(PC_W), .TYPE_W(TYPE_W)) bus ();

    branch_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .TYPE_W(TYPE_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic ent_t mk(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] npc,
                                input logic [TYPE_W-1:0] ty, input logic dir,
                                input logic [1:0] ctr);
        ent_t e;
        e.pc = pc; e.npc = npc; e.ty = ty; e.dir = dir; e.ctr = ctr;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        return mk($urandom, $urandom, TYPE_W'($urandom), 1'($urandom), 2'($urandom));
    endfunction

    // Expected counter: one step toward taken/not-taken, clamped to 0..3.
    function automatic ent_t resolve(input ent_t raw);
        ent_t e = raw;
        int v = raw.dir ? int'(raw.ctr) + 1 : int'(raw.ctr) - 1;
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        e.ctr = 2'(v);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("updateEn", 64'(bus.updateEn_o), 64'(msv));
        if (msv) begin
            chk("updatePC", 64'(bus.updatePC_o), 64'(ms.pc));
            chk("updateNPC", 64'(bus.updateNPC_o), 64'(ms.npc));
            chk("updateCtrlType", 64'(bus.updateCtrlType_o), 64'(ms.ty));
            chk("updateDir", 64'(bus.updateDir_o), 64'(ms.dir));
            chk("updateCounter", 64'(bus.updateCounter_o), 64'(ms.ctr));
        end
        chk("stall", 64'(bus.stall_o), 64'(mq.size() >= DEPTH - 1));
        chk("overflow", 64'(bus.overflow_o), 64'(movf));
    endtask

    task automatic model_reset();
        mq.delete();
        ms   = '0;
        msv  = 1'b0;
        movf = 1'b0;
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic cycle(input bit w0, input ent_t a, input bit w1, input ent_t b, input bit rdy);
        ent_t inl[$];
        bit   stall_m;
        bus.wrEn0_i = w0;  bus.wrPC0_i = a.pc;  bus.wrNPC0_i = a.npc;
        bus.wrCtrlType0_i = a.ty;  bus.wrDir0_i = a.dir;  bus.wrCounter0_i = a.ctr;
        bus.wrEn1_i = w1;  bus.wrPC1_i = b.pc;  bus.wrNPC1_i = b.npc;
        bus.wrCtrlType1_i = b.ty;  bus.wrDir1_i = b.dir;  bus.wrCounter1_i = b.ctr;
        bus.updateReady_i = rdy;
        stall_m = mq.size() >= DEPTH - 1;
        if (stall_m && (w0 || w1)) movf = 1'b1;
        if (!stall_m && w0) inl.push_back(resolve(a));
        if (!stall_m && w1) inl.push_back(resolve(b));
        if (!msv || rdy) begin
            if (mq.size() > 0) begin
                ms = mq.pop_front();
                msv = 1'b1;
`ifdef BUQ_BYPASS_EN
            end else if (inl.size() > 0) begin
                ms = inl.pop_front();
                msv = 1'b1;
`endif
            end else begin
                msv = 1'b0;
            end
        end
        foreach (inl[i]) mq.push_back(inl[i]);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, rdy);
    endtask

    initial begin
        bit   rdy_pat [4];
        ent_t e0, e1;
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        model_reset();
        bus.wrEn0_i = 1'b0; bus.wrEn1_i = 1'b0; bus.updateReady_i = 1'b0;
        bus.wrPC0_i = '0; bus.wrNPC0_i = '0; bus.wrCtrlType0_i = '0; bus.wrDir0_i = 1'b0;
        bus.wrCounter0_i = '0; bus.wrPC1_i = '0; bus.wrNPC1_i = '0; bus.wrCtrlType1_i = '0;
        bus.wrDir1_i = 1'b0; bus.wrCounter1_i = '0;

        // reset state
        #11;
        check_all();
        chk("reset_pc", 64'(bus.updatePC_o), 64'h0);
        chk("reset_ctr", 64'(bus.updateCounter_o), 64'h0);
        #1 reset_n = 1'b1;

        // single write: PC 0x100, NPC 0x200, taken, ctr 2 -> counter 3
        cycle(1'b1, mk(32'h100, 32'h200, 3'd1, 1'b1, 2'd2), 1'b0, '0, 1'b1);
        idle(3, 1'b1);

        // saturation and decrement
        cycle(1'b1, mk(32'h110, 32'h114, 3'd2, 1'b1, 2'd3), 1'b0, '0, 1'b1);
        cycle(1'b1, mk(32'h120, 32'h124, 3'd3, 1'b0, 2'd0), 1'b0, '0, 1'b1);
        cycle(1'b1, mk(32'h130, 32'h134, 3'd4, 1'b0, 2'd2), 1'b0, '0, 1'b1);
        idle(4, 1'b1);

        // fill with ready low until stall, then an overflowing write
        for (int i = 0; i < 4; i++)
            cycle(1'b1, mk(32'h200 + 32'(i * 8), 32'h1, 3'd0, 1'b1, 2'd1),
                  1'b1, mk(32'h204 + 32'(i * 8), 32'h2, 3'd0, 1'b0, 2'd1), 1'b0);
        chk("stall_full", 64'(bus.stall_o), 64'h1);
        cycle(1'b1, mk(32'hdead, 32'hbeef, 3'd7, 1'b1, 2'd0), 1'b0, '0, 1'b0);
        chk("overflow_set", 64'(bus.overflow_o), 64'h1);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, '0, rdy_pat[i % 4]);
        idle(2, 1'b1);

        // five entries drained under ready 1,0,0,1
        cycle(1'b1, mk(32'h300, 32'h0, 3'd1, 1'b1, 2'd0), 1'b1, mk(32'h304, 32'h0, 3'd1, 1'b1, 2'd1), 1'b0);
        cycle(1'b1, mk(32'h308, 32'h0, 3'd1, 1'b0, 2'd3), 1'b1, mk(32'h30c, 32'h0, 3'd1, 1'b0, 2'd1), 1'b0);
        cycle(1'b1, mk(32'h310, 32'h0, 3'd1, 1'b1, 2'd2), 1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b0, '0, rdy_pat[i % 4]);

        // double write A then B with ready high
        cycle(1'b1, mk(32'hA000, 32'hA004, 3'd2, 1'b1, 2'd1), 1'b1, mk(32'hB000, 32'hB004, 3'd5, 1'b0, 2'd1), 1'b1);
        idle(4, 1'b1);

        // asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) cycle(1'b1, rnd_ent(), 1'b1, rnd_ent(), 1'b0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("async_rst_en", 64'(bus.updateEn_o), 64'h0);
        chk("async_rst_pc", 64'(bus.updatePC_o), 64'h0);
        #3 reset_n = 1'b1;
        idle(4, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            e0 = rnd_ent();
            e1 = rnd_ent();
            cycle($urandom_range(0, 2) == 0, e0, $urandom_range(0, 2) == 0, e1,
                  $urandom_range(0, 3) != 0);
        end
        idle(12, 1'b1);
        chk("drained", 64'(mq.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
